// File: rtl/memory_stage.sv
// memory_stage
//   Memory-access pipeline stage. Consumes the Execute stage outputs, runs a
//   data-memory or I/O transaction over a req/ack handshake, pulses the
//   pixel-memory write port, and issues one registered writeback record per
//   operation. While a handshake is outstanding the stage stalls upstream.
//
//   State table
//     state  | meaning
//     IDLE   | accepting ops; plain ops complete here in one cycle
//     ACCESS | dmem/io request outstanding; waiting for ack or timeout
//
// Ports
//   clk, rst                        clock, asynchronous active-low reset
//   in_valid                        Execute outputs valid
//   RegWrite, MemWrite, MemPWrite,
//   IOFlag, MemToReg                controls from Execute
//   ALUResult, WriteData, Rd        address/value, store data, dest register
//   stall                           upstream must hold its inputs
//   mem_addr, mem_wdata             shared address/data for dmem and io
//   dmem_req/we/ack/rdata           data-memory handshake
//   io_req/we/ack/rdata             I/O handshake
//   pmem_we/addr/wdata              pixel-memory write pulse
//   wb_valid, wb_regwrite,
//   wb_rd, wb_data                  writeback record
//   bus_err                         sticky handshake timeout flag

module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        MemPWrite,
    input  logic        IOFlag,
    input  logic [1:0]  MemToReg,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  Rd,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        io_req,
    output logic        io_we,
    input  logic        io_ack,
    input  logic [31:0] io_rdata,
    output logic        pmem_we,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    localparam int             CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Operation context latched at accept of a handshake op
    logic          io_sel;
    logic          store_l;
    logic          regwrite_l;
    logic [3:0]    rd_l;

    logic          is_store;
    logic          is_load;
    logic          is_hs;
    logic          ack_sel;
    logic [31:0]   rdata_sel;
    logic [31:0]   plain_data;

    assign is_store = MemWrite;
    assign is_load  = !MemWrite && (MemToReg == 2'b01);
    assign is_hs    = is_store || is_load;

    // Only the target chosen at accept may complete the access
    assign ack_sel   = io_sel ? io_ack   : dmem_ack;
    assign rdata_sel = io_sel ? io_rdata : dmem_rdata;

    assign stall = (state == ACCESS);

    // A plain op never has MemToReg=01 (that encoding is a load), so only
    // WriteData vs ALUResult needs selecting here.
    always_comb begin
        plain_data = ALUResult;
        if (MemToReg == 2'b10) begin
            plain_data = WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            io_sel      <= 1'b0;
            store_l     <= 1'b0;
            regwrite_l  <= 1'b0;
            rd_l        <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            io_req      <= 1'b0;
            io_we       <= 1'b0;
            pmem_we     <= 1'b0;
            pmem_addr   <= '0;
            pmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            bus_err     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            pmem_we  <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Pixel write rides alongside whatever class the op is
                        if (MemPWrite) begin
                            pmem_we    <= 1'b1;
                            pmem_addr  <= ALUResult;
                            pmem_wdata <= WriteData;
                        end

                        if (is_hs) begin
                            state      <= ACCESS;
                            cnt        <= '0;
                            mem_addr   <= ALUResult;
                            mem_wdata  <= WriteData;
                            io_sel     <= IOFlag;
                            store_l    <= is_store;
                            regwrite_l <= RegWrite;
                            rd_l       <= Rd;
                            dmem_req   <= !IOFlag;
                            dmem_we    <= !IOFlag && is_store;
                            io_req     <= IOFlag;
                            io_we      <= IOFlag && is_store;
                        end else begin
                            wb_valid    <= 1'b1;
                            wb_regwrite <= RegWrite;
                            wb_rd       <= Rd;
                            wb_data     <= plain_data;
                        end
                    end
                end

                ACCESS: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (ack_sel) begin
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        io_req      <= 1'b0;
                        io_we       <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_rd       <= rd_l;
                        wb_regwrite <= regwrite_l && !store_l;
                        wb_data     <= store_l ? mem_addr : rdata_sel;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        io_req      <= 1'b0;
                        io_we       <= 1'b0;
                        bus_err     <= 1'b1;
                        wb_valid    <= 1'b1;
                        wb_rd       <= rd_l;
                        wb_regwrite <= 1'b0;
                        wb_data     <= mem_addr;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
//   Directed and randomized bench for memory_stage. A transaction-level model
//   derives each op's class, handshake length and writeback record from the
//   operation rules; the bench checks the DUT cycle by cycle against it.

module tb_memory_stage;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        RegWrite, MemWrite, MemPWrite, IOFlag;
    logic [1:0]  MemToReg;
    logic [31:0] ALUResult, WriteData;
    logic [3:0]  Rd;
    logic        stall;
    logic [31:0] mem_addr, mem_wdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_rdata;
    logic        io_req, io_we, io_ack;
    logic [31:0] io_rdata;
    logic        pmem_we;
    logic [31:0] pmem_addr, pmem_wdata;
    logic        wb_valid, wb_regwrite;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_err;

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    logic        m_berr;
    logic [3:0]  m_rd;
    logic [31:0] m_data;
    logic        m_known;

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemPWrite(MemPWrite),
        .IOFlag(IOFlag), .MemToReg(MemToReg),
        .ALUResult(ALUResult), .WriteData(WriteData), .Rd(Rd),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .io_req(io_req), .io_we(io_we), .io_ack(io_ack), .io_rdata(io_rdata),
        .pmem_we(pmem_we), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Writeback value from the operation rules
    function automatic logic [31:0] wb_expect(input logic mw, input logic [1:0] m2r,
                                              input logic [31:0] alu, input logic [31:0] wd,
                                              input logic [31:0] ld);
        if (mw) return alu;
        case (m2r)
            2'b01:   return ld;
            2'b10:   return wd;
            default: return alu;
        endcase
    endfunction

    task automatic check_all_zero();
        check("rst_stall", stall, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_io_req", io_req, 0);
        check("rst_io_we", io_we, 0);
        check("rst_pmem_we", pmem_we, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_regwrite", wb_regwrite, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_pmem_addr", pmem_addr, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_bus_err", bus_err, 0);
    endtask

    task automatic randomize_upstream();
        in_valid  = 1'($urandom);
        RegWrite  = 1'($urandom);
        MemWrite  = 1'($urandom);
        MemPWrite = 1'($urandom);
        IOFlag    = 1'($urandom);
        MemToReg  = 2'($urandom);
        ALUResult = $urandom;
        WriteData = $urandom;
        Rd        = 4'($urandom);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        check("idle_wb_valid", wb_valid, 0);
        check("idle_pmem_we", pmem_we, 0);
        check("idle_stall", stall, 0);
        if (m_known) begin
            check("hold_wb_rd", wb_rd, m_rd);
            check("hold_wb_data", wb_data, m_data);
        end
    endtask

    // ack_dly = k>0: ack sampled on the k-th edge after accept; 0: never ack
    task automatic do_op(input logic rw, input logic mw, input logic pw, input logic io,
                         input logic [1:0] m2r, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [3:0] rd, input int ack_dly, input logic [31:0] ld);
        logic hs;
        logic acked;
        int   cyc;
        hs    = mw || (!mw && m2r == 2'b01);
        acked = 1'b0;
        check("pre_stall", stall, 0);
        in_valid = 1'b1; RegWrite = rw; MemWrite = mw; MemPWrite = pw; IOFlag = io;
        MemToReg = m2r; ALUResult = alu; WriteData = wd; Rd = rd;
        // acks while idle must be ignored
        dmem_ack = 1'($urandom); io_ack = 1'($urandom);
        dmem_rdata = $urandom; io_rdata = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_ack = 1'b0; io_ack = 1'b0;
        check("pmem_we", pmem_we, pw);
        if (pw) begin
            check("pmem_addr", pmem_addr, alu);
            check("pmem_wdata", pmem_wdata, wd);
        end
        if (!hs) begin
            check("plain_wb_valid", wb_valid, 1);
            check("plain_wb_rd", wb_rd, rd);
            check("plain_wb_regwrite", wb_regwrite, rw);
            check("plain_wb_data", wb_data, wb_expect(mw, m2r, alu, wd, ld));
            check("plain_stall", stall, 0);
            check("plain_req", {dmem_req, io_req}, 0);
            m_rd = rd; m_data = wb_expect(mw, m2r, alu, wd, ld); m_known = 1'b1;
        end else begin
            cyc = 0;
            while (cyc < TO + 2) begin
                cyc++;
                check("acc_stall", stall, 1);
                check("acc_wb_valid", wb_valid, 0);
                check("acc_sel_req", io ? io_req : dmem_req, 1);
                check("acc_other_req", io ? dmem_req : io_req, 0);
                check("acc_sel_we", io ? io_we : dmem_we, mw);
                check("acc_other_we", io ? dmem_we : io_we, 0);
                check("acc_mem_addr", mem_addr, alu);
                if (mw) check("acc_mem_wdata", mem_wdata, wd);
                if (cyc > 1) check("acc_pmem_we", pmem_we, 0);
                randomize_upstream();
                if (io) begin dmem_ack = 1'($urandom); dmem_rdata = $urandom; end
                else    begin io_ack   = 1'($urandom); io_rdata   = $urandom; end
                if (ack_dly != 0 && cyc == ack_dly) begin
                    if (io) begin io_ack = 1'b1; io_rdata = ld; end
                    else    begin dmem_ack = 1'b1; dmem_rdata = ld; end
                end
                @(posedge clk); #1;
                in_valid = 1'b0; dmem_ack = 1'b0; io_ack = 1'b0;
                if (ack_dly != 0 && cyc == ack_dly) begin
                    acked = 1'b1;
                    break;
                end
                if (ack_dly == 0 && cyc == TO) break;
            end
            check("hs_wb_valid", wb_valid, 1);
            check("hs_stall_drop", stall, 0);
            check("hs_req_drop", {dmem_req, io_req, dmem_we, io_we}, 0);
            check("hs_wb_rd", wb_rd, rd);
            if (acked) begin
                check("hs_wb_regwrite", wb_regwrite, mw ? 1'b0 : rw);
                check("hs_wb_data", wb_data, wb_expect(mw, m2r, alu, wd, ld));
                m_rd = rd; m_data = wb_expect(mw, m2r, alu, wd, ld); m_known = 1'b1;
            end else begin
                check("abort_wb_regwrite", wb_regwrite, 0);
                m_berr = 1'b1;
                m_known = 1'b0;
            end
        end
        check("bus_err", bus_err, m_berr);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0; MemPWrite = 1'b0;
        IOFlag = 1'b0; MemToReg = 2'b00; ALUResult = '0; WriteData = '0; Rd = '0;
        dmem_ack = 1'b0; io_ack = 1'b0; dmem_rdata = '0; io_rdata = '0;
        m_berr = 1'b0; m_rd = '0; m_data = '0; m_known = 1'b1;

        #3;
        check_all_zero();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_check();

        // plain op
        do_op(1, 0, 0, 0, 2'b00, 32'h0000_1234, 32'h0, 4'd3, 0, 32'h0);
        idle_check();
        // dmem load, ack on third edge
        do_op(1, 0, 0, 0, 2'b01, 32'h0000_0100, 32'h0, 4'd5, 3, 32'hDEAD_BEEF);
        // io store, immediate ack, back to back with the previous op
        do_op(1, 1, 0, 1, 2'b00, 32'h0000_0200, 32'h0000_00A5, 4'd6, 1, 32'h0);
        idle_check();
        // store with pixel write
        do_op(0, 1, 1, 0, 2'b00, 32'h0000_0040, 32'h0000_0007, 4'd1, 2, 32'h0);
        // plain ops back to back, MemToReg 10 and 11
        do_op(1, 0, 0, 0, 2'b10, 32'h1111_1111, 32'h2222_2222, 4'd7, 0, 32'h0);
        do_op(0, 0, 1, 1, 2'b11, 32'h3333_3333, 32'h4444_4444, 4'd8, 0, 32'h0);
        // ack on the same edge the timeout would fire: ack wins
        do_op(1, 0, 0, 1, 2'b01, 32'h0000_0300, 32'h0, 4'd9, TO, 32'hCAFE_F00D);
        check("ack_wins_no_berr", bus_err, 0);
        // timeout
        do_op(1, 0, 0, 0, 2'b01, 32'h0000_0400, 32'h0, 4'd10, 0, 32'h0);
        do_op(1, 0, 0, 0, 2'b00, 32'h0000_0500, 32'h0, 4'd11, 0, 32'h0);
        idle_check();

        for (int i = 0; i < 40; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            do_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                  $urandom, $urandom, 4'($urandom), d, $urandom);
            if ($urandom_range(0, 2) == 0) idle_check();
        end

        // reset mid-access with ack arriving in the same cycle
        in_valid = 1'b1; RegWrite = 1'b1; MemWrite = 1'b0; MemPWrite = 1'b0; IOFlag = 1'b0;
        MemToReg = 2'b01; ALUResult = 32'h0000_0600; WriteData = '0; Rd = 4'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_stall", stall, 1);
        check("pre_rst_req", dmem_req, 1);
        #2;
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        #1;
        check_all_zero();
        @(posedge clk); #1;
        check("rst_no_wb", wb_valid, 0);
        check("rst_hold_req", dmem_req, 0);
        rst = 1'b1; dmem_ack = 1'b0;
        m_berr = 1'b0; m_rd = '0; m_data = '0; m_known = 1'b1;
        idle_check();
        do_op(1, 0, 0, 0, 2'b00, 32'h0000_ABCD, 32'h0, 4'd2, 0, 32'h0);
        idle_check();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage that consumes the Execute stage's outputs (ALU result, store data, destination register and the RegWrite/MemWrite/MemPWrite/IOFlag/MemToReg controls). It performs the data-memory or I/O transaction over a req/ack handshake and pulses the pixel-memory write port. It then presents one registered writeback record to the register file. While a handshake transaction is outstanding it stalls the pipeline.

## Interface
Parameters:
- TIMEOUT, 16: cycles `req` may stay high without `ack` before the access is aborted (≥2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  Execute outputs valid this cycle
- RegWrite, MemWrite, MemPWrite, IOFlag  in  1  controls from Execute
- MemToReg  in  2  writeback source select
- ALUResult  in  32  memory address / ALU value
- WriteData  in  32  store data
- Rd  in  4  destination register
- stall  out  1  upstream must hold its inputs
- mem_addr, mem_wdata  out  32  shared address/data for dmem and io
- dmem_req, dmem_we  out  1  data-memory request and write enable; dmem_ack in 1; dmem_rdata in 32
- io_req, io_we  out  1  I/O request and write enable; io_ack in 1; io_rdata in 32
- pmem_we  out  1  pixel-memory write pulse; pmem_addr, pmem_wdata out 32
- wb_valid, wb_regwrite  out  1  writeback record valid, register write enable
- wb_rd  out  4; wb_data  out  32
- bus_err  out  1  sticky timeout flag

## Operation
- Accept occurs on the rising edge where in_valid=1 and stall=0. Inputs are ignored while stall=1.
- Operation classes for an accepted op:
  - Store: MemWrite=1. Store takes precedence over load.
  - Load: MemWrite=0 and MemToReg=01.
  - Handshake op: store or load. Target is io when IOFlag=1, otherwise dmem.
  - Plain op: anything else.
- Pixel write: when MemPWrite=1, pmem_we is 1 for exactly the cycle after accept, with pmem_addr=ALUResult and pmem_wdata=WriteData. This is independent of the class, so MemPWrite can combine with a store.
- FSM states:
  - IDLE: accepting. A plain op loads the writeback register directly. A handshake op latches addr/wdata/we/Rd/RegWrite/MemToReg/target, clears the timeout counter and moves to ACCESS.
  - ACCESS: the selected req is held at 1, with mem_addr/mem_wdata/we stable. stall=1.
    - ack sampled high → back to IDLE; the writeback register loads.
    - Otherwise the counter increments. When it reaches TIMEOUT-1 without ack → abort to IDLE: req drops, bus_err is set, and a writeback record with wb_regwrite=0 is issued.
  - ack and timeout in the same cycle: ack wins.
- Writeback data (wb_data):
  - MemToReg 00 → ALUResult
  - MemToReg 01 → load data (dmem_rdata or io_rdata, sampled on the ack edge)
  - MemToReg 10 → WriteData
  - MemToReg 11 → ALUResult
  - Stores: wb_regwrite=0 regardless of RegWrite; wb_data=ALUResult.
- wb_valid is a single-cycle pulse per completed or aborted op. wb_rd and wb_data hold their values when wb_valid=0.
- ack while not in ACCESS, or ack from the non-selected target: ignored.
- bus_err stays 1 until reset.

## Timing
- stall = (state == ACCESS). It is combinational from state only, never from the inputs.
- Plain op accepted at edge E0 → wb_valid=1 during the cycle after E0 (1-cycle latency).
- Handshake op accepted at E0 → req=1 from after E0. If ack is sampled at edge Ek, req and stall drop after Ek and wb_valid=1 during the cycle after Ek. Minimum latency is 2 edges.
- The next op is accepted no earlier than edge Ek+1.
- Timeout: req is high for exactly TIMEOUT cycles. The abort record appears in the cycle after the edge on which the count reaches TIMEOUT-1.
- Back-to-back plain ops: one writeback per cycle, no bubbles.
- Reset values (asynchronous, effective immediately): state IDLE, counter 0. All outputs are 0: stall, req, we, pmem_we, wb_valid, wb_regwrite, wb_rd, wb_data, mem_addr, mem_wdata, pmem_addr, pmem_wdata, bus_err.
- Reset during ACCESS drops req in the same cycle and produces no writeback. Release of reset resumes in IDLE.

## Test plan
- Plain op: ALUResult=0x0000_1234, Rd=3, RegWrite=1, MemToReg=00 → next cycle wb_valid=1, wb_rd=3, wb_data=0x1234, stall never asserted.
- DMEM load, ack after 3 cycles with dmem_rdata=0xDEAD_BEEF, Rd=5 → dmem_req high 3 cycles at addr=ALUResult, stall high the same cycles, then wb_data=0xDEADBEEF, wb_regwrite=1.
- IO store with IOFlag=1, WriteData=0xA5, immediate io_ack → io_req/io_we for 1 cycle, dmem_req stays 0, wb_regwrite=0.
- Timeout: load with no ack, TIMEOUT=16 → req high exactly 16 cycles, then bus_err=1 (sticky), a wb_valid pulse with wb_regwrite=0, and the next op accepted.
- Store with MemPWrite=1, ALUResult=0x40, WriteData=0x7 → pmem_we pulses 1 cycle (pmem_addr=0x40, pmem_wdata=0x7) concurrently with the dmem handshake.
- Assert rst mid-ACCESS with ack arriving the same cycle → req drops immediately, no wb_valid, all outputs 0; after release a plain op completes normally.
